// File: rtl/pc_sequencer.sv
// pc_sequencer: control sequencer for the program-counter register.
// It arbitrates halt, taken-branch redirects, load-use hazard stalls and
// instruction-memory wait states. After a redirect it raises a pipeline
// flush that kills wrong-path instructions. It also keeps saturating
// stall and branch performance counters.
//
// Ports
//   clk, rst       rising-edge clock; asynchronous active-high reset
//   imem_ready     instruction memory accepts the current fetch
//   br_valid       execute stage resolved a branch this cycle
//   br_taken       resolved branch is taken (qualified by br_valid)
//   br_offset      signed byte offset of the taken branch
//   load_use       one-cycle load-use hazard pulse from decode
//   halt           halt request, sticky until reset
//   pc_stall       hold PC this cycle (combinational)
//   pc_jump        redirect PC this cycle (combinational)
//   pc_branch_amt  offset applied when pc_jump=1, else zero
//   flush          kill instructions in fetch/decode (combinational)
//   halted         controller is in HALT
//   stall_cnt      saturating count of cycles with pc_stall=1
//   br_cnt         saturating count of taken redirects
module pc_sequencer #(
  parameter int FLUSH_CYCLES = 2,
  parameter int STALL_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             imem_ready,
  input  logic             br_valid,
  input  logic             br_taken,
  input  logic [15:0]      br_offset,
  input  logic             load_use,
  input  logic             halt,
  output logic             pc_stall,
  output logic             pc_jump,
  output logic [15:0]      pc_branch_amt,
  output logic             flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] br_cnt
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2,
    HALT  = 2'd3
  } seqState_t;

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);
  localparam logic [3:0] STALL_LOAD = 4'(STALL_CYCLES - 1);

  seqState_t        state;
  seqState_t        stateNext;
  logic [3:0]       cnt;
  logic [3:0]       cntNext;
  logic             stallComb;
  logic             jumpComb;
  logic             flushComb;
  logic             brInc;
  logic             redirect;
  logic [CNT_W-1:0] stallCntR;
  logic [CNT_W-1:0] brCntR;

  // A redirect is only honoured while fetching on the right path and not halting.
  assign redirect = br_valid & br_taken & ((state == RUN) | (state == STALL)) & ~halt;

  // Next-state and PC-control decode, highest priority first: halt, redirect, load_use, imem wait.
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    stallComb = 1'b0;
    jumpComb  = 1'b0;
    flushComb = 1'b0;
    brInc     = 1'b0;
    case (state)
      RUN, STALL: begin
        if (halt) begin
          stallComb = 1'b1;
          stateNext = HALT;
        end else if (redirect) begin
          // The redirect wins over a pending stall or memory wait so the jump is never lost.
          jumpComb  = 1'b1;
          flushComb = 1'b1;
          brInc     = 1'b1;
          cntNext   = FLUSH_LOAD;
          stateNext = FLUSH;
        end else if (state == STALL) begin
          // load_use pulses arriving while already stalled are absorbed.
          stallComb = 1'b1;
          cntNext   = cnt - 4'd1;
          if (cnt == 4'd1) begin
            stateNext = RUN;
          end else begin
            stateNext = STALL;
          end
        end else if (load_use) begin
          // The pulse cycle itself is the first stall cycle.
          stallComb = 1'b1;
          if (STALL_CYCLES > 1) begin
            cntNext   = STALL_LOAD;
            stateNext = STALL;
          end else begin
            stateNext = RUN;
          end
        end else begin
          stallComb = ~imem_ready;
        end
      end
      FLUSH: begin
        flushComb = 1'b1;
        if (halt) begin
          stallComb = 1'b1;
          stateNext = HALT;
        end else if (imem_ready) begin
          // Only accepted fetches retire a wrong-path slot.
          stallComb = 1'b0;
          cntNext   = cnt - 4'd1;
          if (cnt == 4'd1) begin
            stateNext = RUN;
          end else begin
            stateNext = FLUSH;
          end
        end else begin
          stallComb = 1'b1;
        end
      end
      HALT: begin
        stallComb = 1'b1;
        stateNext = HALT;
      end
      default: begin
        stallComb = 1'b1;
        cntNext   = 4'd0;
        stateNext = RUN;
      end
    endcase
  end

  // State and down-counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      cnt   <= 4'd0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stallCntR <= {CNT_W{1'b0}};
      brCntR    <= {CNT_W{1'b0}};
    end else begin
      if (stallComb && (stallCntR != {CNT_W{1'b1}})) begin
        stallCntR <= stallCntR + CNT_W'(1);
      end else begin
        stallCntR <= stallCntR;
      end
      if (brInc && (brCntR != {CNT_W{1'b1}})) begin
        brCntR <= brCntR + CNT_W'(1);
      end else begin
        brCntR <= brCntR;
      end
    end
  end

  // While reset is asserted the PC is held and no redirect or flush escapes.
  assign pc_stall      = rst | stallComb;
  assign pc_jump       = ~rst & jumpComb;
  assign flush         = ~rst & flushComb;
  assign halted        = ~rst & (state == HALT);
  assign pc_branch_amt = pc_jump ? br_offset : 16'd0;
  assign stall_cnt     = stallCntR;
  assign br_cnt        = brCntR;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: scoreboard bench for pc_sequencer.
// Main instance: FLUSH_CYCLES=2, STALL_CYCLES=3, CNT_W=16.
// Second instance: STALL_CYCLES=1, CNT_W=3. It exercises counter saturation.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_ready = 1'b1;
  logic        br_valid = 1'b0;
  logic        br_taken = 1'b0;
  logic [15:0] br_offset = 16'd0;
  logic        load_use = 1'b0;
  logic        halt = 1'b0;
  logic        pc_stall, pc_jump, flush, halted;
  logic [15:0] pc_branch_amt, stall_cnt, br_cnt;

  logic        rst2 = 1'b1;
  logic        imemReady2 = 1'b1;
  logic        loadUse2 = 1'b0;
  logic        zero1 = 1'b0;
  logic [15:0] zero16 = 16'd0;
  logic        pcStall2, pcJump2, flush2, halted2;
  logic [15:0] amt2;
  logic [2:0]  stallCnt2, brCnt2;

  int nChecks = 0;
  int nFails  = 0;
  logic [19:0] expQ[$];

  always #5 clk = ~clk;

  pc_sequencer #(.FLUSH_CYCLES(2), .STALL_CYCLES(3), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .imem_ready(imem_ready), .br_valid(br_valid),
    .br_taken(br_taken), .br_offset(br_offset), .load_use(load_use), .halt(halt),
    .pc_stall(pc_stall), .pc_jump(pc_jump), .pc_branch_amt(pc_branch_amt),
    .flush(flush), .halted(halted), .stall_cnt(stall_cnt), .br_cnt(br_cnt)
  );

  pc_sequencer #(.FLUSH_CYCLES(2), .STALL_CYCLES(1), .CNT_W(3)) dutSat (
    .clk(clk), .rst(rst2), .imem_ready(imemReady2), .br_valid(zero1),
    .br_taken(zero1), .br_offset(zero16), .load_use(loadUse2), .halt(zero1),
    .pc_stall(pcStall2), .pc_jump(pcJump2), .pc_branch_amt(amt2),
    .flush(flush2), .halted(halted2), .stall_cnt(stallCnt2), .br_cnt(brCnt2)
  );

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nFails++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One cycle on the main instance. The expected outputs {stall,jump,flush,halted,amt}
  // are queued with the stimulus and compared at the falling edge.
  task automatic cyc(input string tag, input logic rdy, input logic bv, input logic bt,
                     input logic [15:0] off, input logic lu, input logic hl,
                     input logic eS, input logic eJ, input logic eF, input logic eH,
                     input logic [15:0] eA);
    logic [19:0] expV;
    imem_ready = rdy; br_valid = bv; br_taken = bt; br_offset = off;
    load_use = lu; halt = hl;
    expQ.push_back({eS, eJ, eF, eH, eA});
    @(negedge clk);
    expV = expQ.pop_front();
    checkEq(tag, {12'd0, pc_stall, pc_jump, flush, halted, pc_branch_amt}, {12'd0, expV});
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string tag);
    cyc(tag, 1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    @(negedge clk);
    checkEq("rst_outs", {pc_stall, pc_jump, flush, halted}, 4'b1000);
    checkEq("rst_cnt", {stall_cnt, br_cnt}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // 1: idle run
    for (int i = 0; i < 5; i++) idle("t1_idle");
    checkEq("t1_cnt", {stall_cnt, br_cnt}, 32'd0);

    // 2: taken branch, br_valid during FLUSH is ignored
    cyc("t1_nottaken", 1'b1, 1'b1, 1'b0, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
    cyc("t2_redir", 1'b1, 1'b1, 1'b1, 16'h0040, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0040);
    cyc("t2_fl1", 1'b1, 1'b1, 1'b1, 16'h0080, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0);
    cyc("t2_fl2", 1'b1, 1'b1, 1'b1, 16'h0080, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0);
    idle("t2_end");
    checkEq("t2_brcnt", br_cnt, 32'd1);
    checkEq("t2_stcnt", stall_cnt, 32'd0);

    // 3: load-use stall of three cycles, then a stall aborted by a branch
    cyc("t3_lu", 1'b1, 1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
    cyc("t3_s2", 1'b1, 1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
    cyc("t3_s3", 1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
    idle("t3_run");
    checkEq("t3_stcnt", stall_cnt, 32'd3);
    cyc("t3_lu2", 1'b1, 1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
    cyc("t3_abort", 1'b0, 1'b1, 1'b1, 16'h0010, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0010);
    cyc("t3_fl1", 1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0);
    cyc("t3_fl2", 1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0);
    idle("t3_end");
    checkEq("t3_cnts", {stall_cnt, br_cnt}, {16'd4, 16'd2});

    // 4: FLUSH stretched by memory wait states
    cyc("t4_redir", 1'b1, 1'b1, 1'b1, 16'hFFF0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'hFFF0);
    cyc("t4_w1", 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'd0);
    cyc("t4_w2", 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'd0);
    cyc("t4_fl1", 1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0);
    cyc("t4_fl2", 1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0);
    idle("t4_end");
    cyc("t4_runwait", 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
    checkEq("t4_cnts", {stall_cnt, br_cnt}, {16'd7, 16'd3});

    // 5: halt beats a same-cycle branch, then everything is ignored until reset
    cyc("t5_halt", 1'b1, 1'b1, 1'b1, 16'h0100, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
    for (int i = 0; i < 3; i++)
      cyc("t5_held", 1'b1, 1'b1, 1'b1, 16'h0200, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'd0);
    checkEq("t5_cnts", {stall_cnt, br_cnt}, {16'd11, 16'd3});
    rst = 1'b1;
    @(negedge clk);
    checkEq("t5_rst", {pc_stall, pc_jump, flush, halted}, 4'b1000);
    checkEq("t5_rstcnt", {stall_cnt, br_cnt}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle("t5_run");

    // Reset during FLUSH leaves no residual flush
    cyc("rf_redir", 1'b1, 1'b1, 1'b1, 16'h0008, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0008);
    rst = 1'b1;
    @(negedge clk);
    checkEq("rf_rst", {pc_stall, pc_jump, flush, halted}, 4'b1000);
    @(posedge clk); #1;
    rst = 1'b0;
    idle("rf_run");

    // 6: saturation on the 3-bit instance, and single-cycle load-use stall
    rst2 = 1'b0;
    loadUse2 = 1'b1;
    @(negedge clk);
    checkEq("t6_lu", pcStall2, 32'd1);
    @(posedge clk); #1;
    loadUse2 = 1'b0;
    @(negedge clk);
    checkEq("t6_lu_done", pcStall2, 32'd0);
    @(posedge clk); #1;
    imemReady2 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
    end
    checkEq("t6_almost", stallCnt2, 32'd6);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkEq("t6_stall", pcStall2, 32'd1);
      @(posedge clk); #1;
    end
    checkEq("t6_sat", stallCnt2, 32'd7);
    checkEq("t6_brcnt", brCnt2, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
